// File: rtl/ean13_bar_render_pkg.sv
// ean13_bar_render_pkg: EAN-13 code tables, guard patterns, module positions and FSM state type
// Holds package ean13_pkg, shared by the renderer top and the digit encoder.
package ean13_pkg;
    typedef enum logic [2:0] {S_IDLE, S_CHECK, S_CDIG, S_ENCODE, S_READY} state_t;
    typedef enum logic [1:0] {SET_L, SET_G, SET_R} set_t;
    // L-set codes, MSB is the leftmost module
    localparam logic [6:0] L_CODE [10] = '{7'b0001101, 7'b0011001, 7'b0010011, 7'b0111101, 7'b0100011,
                                            7'b0110001, 7'b0101111, 7'b0111011, 7'b0110111, 7'b0001011};
    // Left-half parity by leading digit: bit 5 = first left data digit, 1 selects the G set
    localparam logic [5:0] PARITY [10] = '{6'b000000, 6'b001011, 6'b001101, 6'b001110, 6'b010011,
                                           6'b011001, 6'b011100, 6'b010101, 6'b010110, 6'b011010};
    localparam logic [2:0] GUARD_SIDE = 3'b101;
    localparam logic [4:0] GUARD_MID  = 5'b01010;
    localparam int N_MOD      = 95;
    localparam int LEFT_BASE  = 3;
    localparam int MID_BASE   = 45;
    localparam int RIGHT_BASE = 50;
    localparam int END_BASE   = 92;

    function automatic logic [3:0] clamp_digit(input logic [3:0] d);
        return (d > 4'd9) ? 4'd0 : d;
    endfunction

    // First module of data digit k (1..12)
    function automatic logic [6:0] mod_base(input logic [3:0] k);
        return (k <= 4'd6) ? 7'(LEFT_BASE + 7 * (int'(k) - 1)) : 7'(RIGHT_BASE + 7 * (int'(k) - 7));
    endfunction
endpackage

// File: rtl/ean13_bar_render_if.sv
// ean13_bar_render_if: digit load handshake, status flags and LCD scan/pixel signals
// master: digit source / LCD side (drives load, digits, loc_x, loc_y)
// slave : renderer (drives busy, ready, chk_err, bar_pixel)
interface ean13_bar_render_if;
    logic             load;
    logic [12:0][3:0] digits;
    logic             busy;
    logic             ready;
    logic             chk_err;
    logic [9:0]       loc_x;
    logic [9:0]       loc_y;
    logic             bar_pixel;

    modport master (output load, digits, loc_x, loc_y, input busy, ready, chk_err, bar_pixel);
    modport slave  (input load, digits, loc_x, loc_y, output busy, ready, chk_err, bar_pixel);
endinterface

// File: rtl/ean13_bar_render_digit_enc.sv
// ean13_digit_enc: maps a digit and code set to its 7-module EAN-13 code (MSB = leftmost module)
// Ports: digit (0..9), set (L/G/R), code (7-bit pattern)
module ean13_digit_enc
    import ean13_pkg::*;
(
    input  logic [3:0] digit,
    input  set_t       set,
    output logic [6:0] code
);
    logic [6:0] l_code, r_code;

    assign l_code = L_CODE[digit];
    assign r_code = ~l_code;
    // G is the mirror image of R
    assign code = (set == SET_L) ? l_code :
                  (set == SET_R) ? r_code :
                  {r_code[0], r_code[1], r_code[2], r_code[3], r_code[4], r_code[5], r_code[6]};
endmodule

// File: rtl/ean13_bar_render.sv
// ean13_bar_render: checks/encodes 13 EAN-13 digits into a 95-module pattern and renders it on the LCD scan
// Ports: clk, rst (sync, active high); bus (slave): load/digits in, busy/ready/chk_err out,
//        loc_x/loc_y scan position in, bar_pixel registered pixel out.
// Config: define CHECKSUM_FIX_EN to encode the computed check digit instead of digits[12].
module ean13_bar_render
    import ean13_pkg::*;
#(
    parameter logic [9:0] X0    = 10'd40,
    parameter logic [9:0] Y0    = 10'd2,
    parameter logic [9:0] BAR_H = 10'd16,
    parameter logic [3:0] MOD_W = 4'd4
) (
    input logic               clk,
    input logic               rst,
    ean13_bar_render_if.slave bus
);
    localparam logic [10:0] X_END = 11'(X0) + 11'(N_MOD * MOD_W);
    localparam logic [10:0] Y_END = 11'(Y0) + 11'(BAR_H);

    state_t           state, state_nx;
    logic [12:0][3:0] dig;
    logic [3:0]       idx, cur, enc_dig, chk;
    logic [7:0]       sum, rem;
    logic [5:0]       lead_par;
    set_t             enc_set;
    logic [6:0]       code;
    logic [N_MOD-1:0] pat;
    logic             busy, ready, chk_err, accept, in_win, bar_pixel;
    logic [3:0]       sub_cnt, cur_sub, sub_nx;
    logic [6:0]       mod_cnt, cur_mod, mod_nx;

    assign accept   = bus.load && (state == S_IDLE || state == S_READY);
    assign cur      = clamp_digit(dig[idx]);
    // sum is frozen after CHECK, so chk stays valid through CDIG and ENCODE
    assign rem      = sum % 8'd10;
    assign chk      = (rem == 8'd0) ? 4'd0 : 4'(8'd10 - rem);
`ifdef CHECKSUM_FIX_EN
    assign enc_dig  = (idx == 4'd12) ? chk : cur;
`else
    assign enc_dig  = cur;
`endif
    assign lead_par = PARITY[clamp_digit(dig[0])];
    assign enc_set  = (idx > 4'd6) ? SET_R : lead_par[3'(4'd6 - idx)] ? SET_G : SET_L;

    ean13_digit_enc u_enc (.digit(enc_dig), .set(enc_set), .code(code));

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            S_IDLE, S_READY: if (bus.load) state_nx = S_CHECK;
            S_CHECK:         if (idx == 4'd11) state_nx = S_CDIG;
            S_CDIG:          state_nx = S_ENCODE;
            S_ENCODE:        if (idx == 4'd12) state_nx = S_READY;
            default:         state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dig     <= '0;
            idx     <= '0;
            sum     <= '0;
            pat     <= '0;
            busy    <= 1'b0;
            ready   <= 1'b0;
            chk_err <= 1'b0;
        end else begin
            // flags follow the state one edge late: busy from the edge after acceptance, ready 26 edges after
            busy  <= state inside {S_CHECK, S_CDIG, S_ENCODE};
            ready <= (state == S_READY) && !accept;
            if (accept) begin
                dig     <= bus.digits;
                idx     <= '0;
                sum     <= '0;
                chk_err <= 1'b0;
            end else if (state == S_CHECK) begin
                sum <= sum + (idx[0] ? 8'd3 * 8'(cur) : 8'(cur));
                if (dig[idx] > 4'd9) chk_err <= 1'b1;
                idx <= idx + 4'd1;
            end else if (state == S_CDIG) begin
                pat[0 +: 3]        <= GUARD_SIDE;
                pat[MID_BASE +: 5] <= GUARD_MID;
                pat[END_BASE +: 3] <= GUARD_SIDE;
                idx                <= 4'd1;
`ifndef CHECKSUM_FIX_EN
                if (dig[12] != chk) chk_err <= 1'b1;
`endif
            end else if (state == S_ENCODE) begin
                pat[mod_base(idx) +: 7] <= {code[0], code[1], code[2], code[3], code[4], code[5], code[6]};
                idx                     <= idx + 4'd1;
            end
        end
    end

    // Counters hold the module position of the next pixel; loc_x == X0 restarts them at module 0
    assign cur_sub = (bus.loc_x == X0) ? 4'd0 : sub_cnt;
    assign cur_mod = (bus.loc_x == X0) ? 7'd0 : mod_cnt;
    assign sub_nx  = (cur_sub == MOD_W - 4'd1) ? 4'd0 : cur_sub + 4'd1;
    assign mod_nx  = (cur_sub == MOD_W - 4'd1 && cur_mod != 7'(N_MOD)) ? cur_mod + 7'd1 : cur_mod;
    assign in_win  = (bus.loc_y >= Y0) && ({1'b0, bus.loc_y} < Y_END) &&
                     (bus.loc_x >= X0) && ({1'b0, bus.loc_x} < X_END) && (cur_mod < 7'(N_MOD));

    always_ff @(posedge clk) begin
        if (rst) begin
            sub_cnt   <= '0;
            mod_cnt   <= '0;
            bar_pixel <= 1'b0;
        end else begin
            sub_cnt   <= sub_nx;
            mod_cnt   <= mod_nx;
            bar_pixel <= ready && in_win && pat[cur_mod];
        end
    end

    assign bus.busy      = busy;
    assign bus.ready     = ready;
    assign bus.chk_err   = chk_err;
    assign bus.bar_pixel = bar_pixel;
endmodule

// File: tb/tb_ean13_bar_render.sv
// tb_ean13_bar_render: scoreboard bench for ean13_bar_render (directed digit vectors, row scans)
module tb_ean13_bar_render;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ean13_bar_render_if bus();
    ean13_bar_render dut (.clk(clk), .rst(rst), .bus(bus));

`ifdef CHECKSUM_FIX_EN
    localparam bit FIX = 1'b1;
`else
    localparam bit FIX = 1'b0;
`endif

    typedef struct packed {logic chk; logic exp; logic [9:0] x; logic [9:0] y;} pix_t;

    int    total = 0;
    int    bad = 0;
    pix_t  pix_q[$];
    logic  done_q[$];
    string name_q[$];
    string scan_name = "";
    time   t_acc = 0;
    logic  scan_vld = 1'b0;
    logic  vld_d = 1'b0;
    logic  rdy_prev = 1'b0;
    pix_t  mp;
    logic  me;
    string mn;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    // Monitor: one pixel sample per scan cycle, one completion record per ready rise
    always @(posedge clk) vld_d <= scan_vld;
    always @(negedge clk) begin
        if (vld_d) begin
            if (pix_q.size() == 0) check("pix_underflow", 1, 0);
            else begin
                mp = pix_q.pop_front();
                if (mp.chk) check($sformatf("%s x=%0d y=%0d", scan_name, mp.x, mp.y), int'(bus.bar_pixel), int'(mp.exp));
            end
        end
        if (bus.ready && !rdy_prev) begin
            if (done_q.size() == 0) check("unexpected_ready", 1, 0);
            else begin
                me = done_q.pop_front();
                mn = name_q.pop_front();
                check({mn, "_latency"}, int'(($time - 5 - t_acc) / 10), 26);
                check({mn, "_chk_err"}, int'(bus.chk_err), int'(me));
                check({mn, "_busy_low"}, int'(bus.busy), 0);
            end
        end
        rdy_prev = bus.ready;
    end

    function automatic logic [12:0][3:0] mk(input string s);
        logic [12:0][3:0] d;
        for (int i = 0; i < 13; i++) d[i] = 4'(s[i] - 8'h30);
        return d;
    endfunction

    function automatic logic [94:0] put(input logic [94:0] v, input int base, input string s);
        for (int j = 0; j < s.len(); j++) v[base + j] = (s[j] == 8'h31);
        return v;
    endfunction

    task automatic do_load(input logic [12:0][3:0] d, input string name, input logic exp_err, input bit expect_done);
        @(negedge clk);
        bus.digits = d;
        bus.load   = 1'b1;
        if (expect_done) begin
            done_q.push_back(exp_err);
            name_q.push_back(name);
        end
        @(posedge clk);
        t_acc = $time;
        @(negedge clk);
        bus.load = 1'b0;
    endtask

    task automatic wait_ready(input string name);
        int n = 0;
        while (!bus.ready && n < 60) begin
            @(negedge clk);
            n++;
        end
        check({name, "_ready_seen"}, int'(bus.ready), 1);
    endtask

    task automatic scan(input int y, input logic [94:0] pat, input logic [94:0] msk, input string name);
        pix_t p;
        scan_name = name;
        for (int x = 36; x < 424; x++) begin
            @(negedge clk);
            bus.loc_x = 10'(x);
            bus.loc_y = 10'(y);
            scan_vld  = 1'b1;
            p.x = 10'(x);
            p.y = 10'(y);
            if (y >= 2 && y < 18 && x >= 40 && x < 420) begin
                p.chk = msk[(x - 40) / 4];
                p.exp = pat[(x - 40) / 4];
            end else begin
                p.chk = 1'b1;
                p.exp = 1'b0;
            end
            pix_q.push_back(p);
        end
        @(negedge clk);
        scan_vld = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [94:0] p1, m1, p2, pz, full;
        logic [12:0][3:0] da;
        bus.load   = 1'b0;
        bus.digits = '0;
        bus.loc_x  = '0;
        bus.loc_y  = '0;
        p1 = '0;
        p1 = put(p1, 0, "101");
        p1 = put(p1, 3, "0111011");
        p1 = put(p1, 10, "0001001");
        p1 = put(p1, 17, "0010001");
        p1 = put(p1, 24, "0011001");
        p1 = put(p1, 45, "01010");
        p1 = put(p1, 78, "1110010");
        p1 = put(p1, 85, "1101100");
        p1 = put(p1, 92, "101");
        m1 = '0;
        m1 = put(m1, 0, "111");
        for (int k = 0; k < 4; k++) m1 = put(m1, 3 + 7 * k, "1111111");
        m1 = put(m1, 45, "11111");
        m1 = put(m1, 78, "11111111111111");
        m1 = put(m1, 92, "111");
        p2 = put(p1, 85, FIX ? "1101100" : "1001110");
        pz = '0;
        pz = put(pz, 0, "101");
        for (int k = 0; k < 6; k++) pz = put(pz, 3 + 7 * k, "0001101");
        pz = put(pz, 45, "01010");
        for (int k = 0; k < 6; k++) pz = put(pz, 50 + 7 * k, "1110010");
        pz = put(pz, 92, "101");
        full = '1;

        repeat (3) @(negedge clk);
        check("reset_busy", int'(bus.busy), 0);
        check("reset_ready", int'(bus.ready), 0);
        check("reset_chk_err", int'(bus.chk_err), 0);
        check("reset_bar_pixel", int'(bus.bar_pixel), 0);
        rst = 1'b0;

        do_load(mk("9787115279002"), "t1", 1'b0, 1'b1);
        bus.digits = '0;
        repeat (3) @(negedge clk);
        check("t1_busy", int'(bus.busy), 1);
        @(negedge clk);
        bus.load = 1'b1;
        @(negedge clk);
        bus.load = 1'b0;
        wait_ready("t1");
        scan(2, p1, m1, "t1_row_top");
        scan(17, p1, m1, "t1_row_bottom");
        scan(18, '0, '0, "t1_row_below");
        scan(1, '0, '0, "t1_row_above");

        do_load(mk("9787115279005"), "t2", !FIX, 1'b1);
        check("t2_ready_drop", int'(bus.ready), 0);
        wait_ready("t2");
        scan(2, p2, m1, "t2_row");

        do_load(mk("0000000000000"), "t3", 1'b0, 1'b1);
        wait_ready("t3");
        scan(10, pz, full, "t3_zeros");

        da = '0;
        da[3] = 4'hA;
        do_load(da, "t4", 1'b1, 1'b1);
        wait_ready("t4");
        scan(2, pz, full, "t4_hexA");

        do_load(mk("9787115279002"), "t5", 1'b0, 1'b0);
        repeat (18) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("t5_rst_busy", int'(bus.busy), 0);
        check("t5_rst_ready", int'(bus.ready), 0);
        check("t5_rst_bar_pixel", int'(bus.bar_pixel), 0);
        rst = 1'b0;
        repeat (40) @(negedge clk);
        check("t5_stays_idle", int'(bus.ready), 0);

        do_load(mk("0000000000000"), "t6", 1'b0, 1'b1);
        wait_ready("t6");
        scan(5, pz, full, "t6_after_rst");

        check("done_q_empty", done_q.size(), 0);
        check("pix_q_empty", pix_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
